// File: rtl/sisc_pkg.sv
// sisc_pkg -- shared constants for the SISC controller.
//   Opcode values (4-bit instruction field [31:28]), ALU operation
//   encodings and the controller state encoding.
package sisc_pkg;

    // Instruction opcodes
    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_REG_OP = 4'h1;
    localparam logic [3:0] OP_REG_IM = 4'h2;
    localparam logic [3:0] OP_BNE    = 4'h4;
    localparam logic [3:0] OP_BRA    = 4'h5;
    localparam logic [3:0] OP_LOD    = 4'h8;
    localparam logic [3:0] OP_STR    = 4'h9;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // ALU operation select
    localparam logic [1:0] ALU_RR   = 2'b00;  // register-register
    localparam logic [1:0] ALU_RI   = 2'b01;  // register-immediate
    localparam logic [1:0] ALU_ADDR = 2'b10;  // address add
    localparam logic [1:0] ALU_PASS = 2'b11;  // pass-through

    // Controller states
    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/sisc_brcond.sv
// sisc_brcond -- branch condition evaluation.
//   opcode : latched instruction opcode
//   mm     : latched mode/mask field
//   stat   : live status register {carry, overflow, negative, zero}
//   taken  : 1 when the instruction is a branch whose condition holds
//   BRA is taken when the mask is empty or any masked status bit is set;
//   BNE is taken when no masked status bit is set. Other opcodes never take.
module sisc_brcond
    import sisc_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int MM_W  = 4
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [MM_W-1:0]  mm,
    input  logic [MM_W-1:0]  stat,
    output logic             taken
);

    logic [MM_W-1:0] hit;
    logic            any_hit;

    generate
        for (genvar gi = 0; gi < MM_W; gi++) begin : g_hit
            assign hit[gi] = mm[gi] & stat[gi];
        end
    endgenerate

    assign any_hit = |hit;

    always_comb begin
        taken = 1'b0;
        if (opcode == OPC_W'(OP_BRA)) begin
            taken = (mm == '0) || any_hit;
        end else if (opcode == OPC_W'(OP_BNE)) begin
            taken = !any_hit;
        end
    end

endmodule

// File: rtl/sisc_ctrl_p.sv
// sisc_ctrl_p -- multi-cycle SISC instruction controller.
//   clk, rst_f          : clock, synchronous active-high reset
//   ir_valid / ir_ready : instruction handshake (ready only in FETCH)
//   opcode, mm          : instruction fields, captured on transfer
//   stat                : live status register, used for branch decisions
//   mem_ready           : memory completion
//   mem_req, mem_we     : memory request / write qualifier
//   rf_we, sr_enable    : register-file / status-register write enables
//   wb_sel              : writeback source (0 ALU, 1 memory)
//   pc_write, br_taken  : PC update, branch redirect
//   alu_op              : ALU operation select
//   halted, fault       : terminal state indicators
// Outputs are decoded from the registered state and the captured
// instruction; only br_taken/pc_write in EXECUTE also look at stat.
module sisc_ctrl_p
    import sisc_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int MM_W     = 4,
    parameter int STAT_W   = 4,
    parameter int ALU_OP_W = 2,
    parameter int MEM_TMO  = 15
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic                ir_valid,
    output logic                ir_ready,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [MM_W-1:0]     mm,
    input  logic [STAT_W-1:0]   stat,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                rf_we,
    output logic                sr_enable,
    output logic                wb_sel,
    output logic                pc_write,
    output logic                br_taken,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                fault
);

    localparam int CNT_W = $clog2(MEM_TMO + 1);

    state_t            state_reg, state_next;
    logic [OPC_W-1:0]  opc_reg;
    logic [MM_W-1:0]   mm_reg;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              cond_taken;

    logic is_reg_op, is_reg_im, is_lod, is_str, is_branch;

    assign is_reg_op = (opc_reg == OPC_W'(OP_REG_OP));
    assign is_reg_im = (opc_reg == OPC_W'(OP_REG_IM));
    assign is_lod    = (opc_reg == OPC_W'(OP_LOD));
    assign is_str    = (opc_reg == OPC_W'(OP_STR));
    assign is_branch = (opc_reg == OPC_W'(OP_BRA)) || (opc_reg == OPC_W'(OP_BNE));

    sisc_brcond #(
        .OPC_W (OPC_W),
        .MM_W  (MM_W)
    ) u_brcond (
        .opcode (opc_reg),
        .mm     (mm_reg),
        .stat   (stat),
        .taken  (cond_taken)
    );

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_reg    <= ST_START;
            opc_reg      <= '0;
            mm_reg       <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            // ir_ready is exactly "in FETCH", so this is the transfer
            if (state_reg == ST_FETCH && ir_valid) begin
                opc_reg <= opcode;
                mm_reg  <= mm;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;          // counter only survives inside MEM
        ir_ready      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        rf_we         = 1'b0;
        sr_enable     = 1'b0;
        wb_sel        = 1'b0;
        pc_write      = 1'b0;
        br_taken      = 1'b0;
        alu_op        = ALU_OP_W'(ALU_RR);
        halted        = 1'b0;
        fault         = 1'b0;

        case (state_reg)
            ST_START: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                ir_ready = 1'b1;
                if (ir_valid) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // first cycle after the transfer: the PC-advance pulse
                pc_write = 1'b1;
                if (opc_reg == OPC_W'(OP_NOOP)) begin
                    state_next = ST_FETCH;
                end else if (opc_reg == OPC_W'(OP_HLT)) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                // undefined opcodes fall through with everything idle
                state_next = ST_FETCH;
                if (is_reg_op) begin
                    alu_op     = ALU_OP_W'(ALU_RR);
                    state_next = ST_WRITEBACK;
                end else if (is_reg_im) begin
                    alu_op     = ALU_OP_W'(ALU_RI);
                    state_next = ST_WRITEBACK;
                end else if (is_branch) begin
                    br_taken = cond_taken;
                    pc_write = cond_taken;
                end else if (is_lod || is_str) begin
                    alu_op     = ALU_OP_W'(ALU_ADDR);
                    state_next = ST_MEM;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_str;
                // mem_ready is tested first so it wins on the timeout cycle
                if (mem_ready) begin
                    state_next = is_lod ? ST_WRITEBACK : ST_FETCH;
                end else if (wait_cnt_reg == CNT_W'(MEM_TMO - 1)) begin
                    state_next = ST_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                rf_we      = 1'b1;
                wb_sel     = is_lod;
                sr_enable  = is_reg_op || is_reg_im;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = ST_START;
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_p.sv
// tb_sisc_ctrl_p -- self-checking bench for sisc_ctrl_p.
//   A per-instruction reference model lists the expected output word for
//   every cycle of one instruction; the bench replays it cycle by cycle.
//   Directed table entries also check per-instruction summaries.
module tb_sisc_ctrl_p;

    localparam int TMO = 15;

    typedef struct packed {
        logic       ir_ready;
        logic       pc_write;
        logic       br_taken;
        logic [1:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic       rf_we;
        logic       sr_enable;
        logic       wb_sel;
        logic       halted;
        logic       fault;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] mm;
        logic [3:0] st;
        int         lat;
        int         stall;
        int         e_taken;
        int         e_mem;
        int         e_rfwe;
        int         e_wbsel;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_f = 1'b1;
    logic       ir_valid = 1'b0;
    logic       ir_ready;
    logic [3:0] opcode = '0;
    logic [3:0] mm = '0;
    logic [3:0] stat = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, rf_we, sr_enable, wb_sel, pc_write, br_taken;
    logic [1:0] alu_op;
    logic       halted, fault;

    out_t obs;
    out_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   obs_taken, obs_mem, obs_rfwe, obs_wbsel, obs_halt, obs_fault;

    always #5 clk = ~clk;

    sisc_ctrl_p #(
        .OPC_W(4), .MM_W(4), .STAT_W(4), .ALU_OP_W(2), .MEM_TMO(TMO)
    ) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .rf_we     (rf_we),
        .sr_enable (sr_enable),
        .wb_sel    (wb_sel),
        .pc_write  (pc_write),
        .br_taken  (br_taken),
        .alu_op    (alu_op),
        .halted    (halted),
        .fault     (fault)
    );

    always_comb obs = {ir_ready, pc_write, br_taken, alu_op, mem_req, mem_we,
                       rf_we, sr_enable, wb_sel, halted, fault};

    task automatic check_out(input string tag, input out_t e);
        vec_cnt++;
        if (obs !== e) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b", tag, obs, e);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int e);
        vec_cnt++;
        if (got != e) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, e);
        end
    endtask

    // Reference model: expected outputs of every cycle from the first FETCH
    // cycle of an instruction until the controller is back in FETCH (or has
    // sat three cycles in a terminal state). lat = not-ready memory cycles
    // before mem_ready; lat >= TMO means memory never answers in time.
    task automatic build_exp(input logic [3:0] op, input logic [3:0] mm_i,
                             input logic [3:0] st_i, input int lat,
                             input int stall, output bit term);
        out_t z, o;
        bit   hit, t;
        int   n;
        z = '0;
        term = 1'b0;
        exp_q.delete();
        for (int s = 0; s <= stall; s++) begin
            o = z; o.ir_ready = 1'b1; exp_q.push_back(o);
        end
        o = z; o.pc_write = 1'b1; exp_q.push_back(o);
        if (op == 4'h0) return;
        if (op == 4'hF) begin
            o = z; o.halted = 1'b1;
            repeat (3) exp_q.push_back(o);
            term = 1'b1;
            return;
        end
        o = z;
        case (op)
            4'h1, 4'h2: begin
                o.alu_op = (op == 4'h1) ? 2'd0 : 2'd1;
                exp_q.push_back(o);
                o = z; o.rf_we = 1'b1; o.sr_enable = 1'b1;
                exp_q.push_back(o);
            end
            4'h4, 4'h5: begin
                hit = (mm_i & st_i) != 4'h0;
                t = (op == 4'h5) ? ((mm_i == 4'h0) || hit) : !hit;
                o.br_taken = t; o.pc_write = t;
                exp_q.push_back(o);
            end
            4'h8, 4'h9: begin
                o.alu_op = 2'd2;
                exp_q.push_back(o);
                n = (lat < TMO) ? lat + 1 : TMO;
                o = z; o.mem_req = 1'b1; o.mem_we = (op == 4'h9);
                repeat (n) exp_q.push_back(o);
                if (lat >= TMO) begin
                    o = z; o.fault = 1'b1;
                    repeat (3) exp_q.push_back(o);
                    term = 1'b1;
                end else if (op == 4'h8) begin
                    o = z; o.rf_we = 1'b1; o.wb_sel = 1'b1;
                    exp_q.push_back(o);
                end
            end
            default: exp_q.push_back(z);
        endcase
    endtask

    // Apply one instruction starting at a negedge with the DUT in FETCH.
    // stop_at >= 0 abandons the instruction after that many cycles.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm_i,
                             input logic [3:0] st_i, input int lat,
                             input int stall, input int stop_at,
                             output bit term);
        out_t e;
        int   idx;
        build_exp(op, mm_i, st_i, lat, stall, term);
        obs_taken = 0; obs_mem = 0; obs_rfwe = 0; obs_wbsel = 0;
        obs_halt = 0; obs_fault = 0;
        idx = 0;
        while (exp_q.size() > 0 && (stop_at < 0 || idx < stop_at)) begin
            e = exp_q.pop_front();
            if (idx < stall)       ir_valid = 1'b0;
            else if (idx == stall) ir_valid = 1'b1;
            else                   ir_valid = 1'($urandom_range(0, 1));
            opcode    = (idx == stall) ? op   : 4'($urandom);
            mm        = (idx == stall) ? mm_i : 4'($urandom);
            stat      = st_i;
            mem_ready = (lat < TMO) && (idx == stall + 3 + lat);
            #1;
            check_out($sformatf("op%h cyc%0d", op, idx), e);
            obs_taken += int'(obs.br_taken);
            obs_mem   += int'(obs.mem_req);
            obs_rfwe  += int'(obs.rf_we);
            obs_wbsel += int'(obs.wb_sel);
            obs_halt  += int'(obs.halted);
            obs_fault += int'(obs.fault);
            idx++;
            @(negedge clk);
        end
        exp_q.delete();
        ir_valid  = 1'b0;
        mem_ready = 1'b0;
    endtask

    // Reset for one edge; START must show all-zero outputs, then FETCH.
    task automatic do_reset();
        out_t o;
        rst_f = 1'b1; ir_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check_out("reset start", '0);
        rst_f = 1'b0; ir_valid = 1'b0;
        @(negedge clk);
        o = '0; o.ir_ready = 1'b1;
        #1;
        check_out("reset fetch", o);
    endtask

    vec_t tbl[14];
    bit   term;

    initial begin
        tbl[0]  = '{4'h1, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0};   // REG_OP
        tbl[1]  = '{4'h5, 4'h1, 4'h1, 0, 0, 1, 0, 0, 0};   // BRA taken
        tbl[2]  = '{4'h5, 4'h1, 4'h0, 0, 0, 0, 0, 0, 0};   // BRA not taken
        tbl[3]  = '{4'h4, 4'h4, 4'h0, 0, 0, 1, 0, 0, 0};   // BNE taken
        tbl[4]  = '{4'h4, 4'h4, 4'h4, 0, 0, 0, 0, 0, 0};   // BNE not taken
        tbl[5]  = '{4'h5, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0};   // BRA empty mask
        tbl[6]  = '{4'h8, 4'h0, 4'h0, 3, 0, 0, 4, 1, 1};   // LOD, 3 waits
        tbl[7]  = '{4'h9, 4'h0, 4'h0, 3, 0, 0, 4, 0, 0};   // STR, 3 waits
        tbl[8]  = '{4'h8, 4'h0, 4'h0, 14, 0, 0, 15, 1, 1}; // ready on 15th
        tbl[9]  = '{4'h7, 4'h0, 4'h0, 0, 2, 0, 0, 0, 0};   // undefined
        tbl[10] = '{4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0};   // NOOP
        tbl[11] = '{4'h2, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0};   // REG_IM
        tbl[12] = '{4'h4, 4'h3, 4'h8, 0, 0, 1, 0, 0, 0};   // BNE, other bit set
        tbl[13] = '{4'h5, 4'h6, 4'h1, 0, 0, 0, 0, 0, 0};   // BRA, no overlap

        @(negedge clk);
        do_reset();
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].op, tbl[i].mm, tbl[i].st, tbl[i].lat,
                      tbl[i].stall, -1, term);
            check_int($sformatf("tbl%0d taken", i), obs_taken, tbl[i].e_taken);
            check_int($sformatf("tbl%0d mem", i),   obs_mem,   tbl[i].e_mem);
            check_int($sformatf("tbl%0d rf_we", i), obs_rfwe,  tbl[i].e_rfwe);
            check_int($sformatf("tbl%0d wb_sel", i), obs_wbsel, tbl[i].e_wbsel);
        end

        // Memory never answers: fault after the full wait budget
        run_instr(4'h8, 4'h0, 4'h0, 99, 0, -1, term);
        check_int("timeout mem cycles", obs_mem, TMO);
        check_int("timeout fault", obs_fault, 3);
        do_reset();
        @(negedge clk);

        // HLT is terminal, ir_ready stays low
        run_instr(4'hF, 4'h0, 4'h0, 0, 0, -1, term);
        check_int("halt halted", obs_halt, 3);
        do_reset();
        @(negedge clk);

        // Reset in the middle of a memory wait, then a long wait must still
        // complete without a fault
        run_instr(4'h8, 4'h0, 4'h0, 99, 0, 8, term);
        check_int("midmem mem cycles", obs_mem, 5);
        do_reset();
        @(negedge clk);
        run_instr(4'h8, 4'h0, 4'h0, 14, 0, -1, term);
        check_int("after reset fault", obs_fault, 0);

        // Random instruction stream
        for (int i = 0; i < 120; i++) begin
            run_instr(4'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 16), $urandom_range(0, 2), -1, term);
            if (term) begin
                do_reset();
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
